prc_vs_status_monitor: RTL and testbench

//   Sits between the PRC virtual-socket status AXIS channels and the ICAP arbiter. Tracks each

---
 rtl/prc_vs_status_monitor.sv | 143 ++++++++++++++
 tb/tb_prc_vs_status_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prc_vs_status_monitor.sv
// Per-virtual-socket load/error tracker feeding the ICAP arbiter's release qualification.
// Each VS runs IDLE/LOADING/ERR with a saturating load timeout; error flags stay set until cleared.
module prc_vs_status_monitor #(
  parameter int unsigned NUM_VS         = 2,
  parameter int unsigned TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                  icap_clk,
  input  logic                  icap_resetn,
  input  logic [32*NUM_VS-1:0]  vs_axis_status_tdata,
  input  logic [NUM_VS-1:0]     vs_axis_status_tvalid,
  input  logic                  err_clear,
  output logic                  loading_any,
  output logic                  loading_end,
  output logic                  release_ok,
  output logic [NUM_VS-1:0]     err_sticky,
  output logic [4*NUM_VS-1:0]   err_code,
  output logic [NUM_VS-1:0]     timeout_err
);

  localparam logic [2:0]           S_LOADING = 3'b100;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  if ((NUM_VS < 1) || (NUM_VS > 8)) begin : g_bad_num_vs
    $error("prc_vs_status_monitor: NUM_VS must be 1..8");
  end
  if ((TIMEOUT_CYCLES == 0) || (64'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_W))) begin : g_bad_timeout
    $error("prc_vs_status_monitor: TIMEOUT_CYCLES must be in 1..2**TIMEOUT_W-1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOADING, ST_ERR} vs_state_e;

  vs_state_e            state_q [NUM_VS];
  vs_state_e            state_d [NUM_VS];
  logic [TIMEOUT_W-1:0] cnt_q   [NUM_VS];
  logic [TIMEOUT_W-1:0] cnt_d   [NUM_VS];
  logic [NUM_VS-1:0]    sticky_d;
  logic [NUM_VS-1:0]    tmo_d;
  logic [NUM_VS-1:0]    end_d;
  logic [NUM_VS-1:0]    busy_d;
  logic [NUM_VS-1:0]    load_d;
  logic [4*NUM_VS-1:0]  code_d;

  // Status bits [31:7] carry nothing this block uses.
  logic [NUM_VS-1:0] unused_hi;
  for (genvar g = 0; g < NUM_VS; g++) begin : g_unused
    assign unused_hi[g] = ^vs_axis_status_tdata[32*g+7 +: 25];
  end

  // Next state, counters and flags for every VS.
  always_comb begin
    logic [2:0] s;
    logic [3:0] e;
    logic       beat;
    logic       err_beat;
    s        = '0;
    e        = '0;
    beat     = 1'b0;
    err_beat = 1'b0;
    sticky_d = err_sticky;
    tmo_d    = timeout_err;
    code_d   = err_code;
    end_d    = '0;
    busy_d   = '0;
    load_d   = '0;
    for (int i = 0; i < NUM_VS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      s          = vs_axis_status_tdata[32*i +: 3];
      e          = vs_axis_status_tdata[32*i+3 +: 4];
      beat       = vs_axis_status_tvalid[i];
      err_beat   = beat && (e != 4'd0);

      if (err_clear) begin
        sticky_d[i]     = 1'b0;
        tmo_d[i]        = 1'b0;
        code_d[4*i +: 4] = 4'd0;
      end
      // A new error beat outranks a same-cycle clear; only the first code is held.
      if (err_beat) begin
        if (!sticky_d[i]) code_d[4*i +: 4] = e;
        sticky_d[i] = 1'b1;
      end

      case (state_q[i])
        ST_IDLE: begin
          if (err_beat) begin
            state_d[i] = ST_ERR;
          end else if (beat && (s == S_LOADING)) begin
            state_d[i] = ST_LOADING;
            cnt_d[i]   = '0;
          end
        end
        ST_LOADING: begin
          if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + TIMEOUT_W'(1);
          if (err_beat) begin
            state_d[i] = ST_ERR;
          end else if (beat && (s != S_LOADING)) begin
            state_d[i] = ST_IDLE;
            end_d[i]   = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_ERR;
            tmo_d[i]   = 1'b1;
          end
        end
        ST_ERR: begin
          if (err_clear && !err_beat) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase

      load_d[i] = (state_d[i] == ST_LOADING);
      busy_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  always_ff @(posedge icap_clk or negedge icap_resetn) begin
    if (!icap_resetn) begin
      for (int i = 0; i < NUM_VS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      loading_any <= 1'b0;
      loading_end <= 1'b0;
      release_ok  <= 1'b1;
      err_sticky  <= '0;
      err_code    <= '0;
      timeout_err <= '0;
    end else begin
      for (int i = 0; i < NUM_VS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      loading_any <= |load_d;
      loading_end <= |end_d;
      release_ok  <= ~(|busy_d) & ~(|sticky_d) & ~(|tmo_d);
      err_sticky  <= sticky_d;
      err_code    <= code_d;
      timeout_err <= tmo_d;
    end
  end

endmodule

// File: tb/tb_prc_vs_status_monitor.sv
// Bench for prc_vs_status_monitor: directed scenarios followed by random status traffic,
// all compared every cycle against a timestamp-based reference model.
module tb_prc_vs_status_monitor;

  localparam int unsigned NVS = 2;
  localparam int unsigned TW  = 8;
  localparam int unsigned TC  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [32*NVS-1:0] tdata;
  logic [NVS-1:0]    tvalid;
  logic              clr;
  logic              loading_any;
  logic              loading_end;
  logic              release_ok;
  logic [NVS-1:0]    err_sticky;
  logic [4*NVS-1:0]  err_code;
  logic [NVS-1:0]    timeout_err;

  int total = 0;
  int bad   = 0;

  // Reference model: what each VS is doing, when its load started, and its flags.
  bit       m_load   [NVS];
  bit       m_err    [NVS];
  int       m_start  [NVS];
  bit       m_sticky [NVS];
  bit       m_tmo    [NVS];
  bit [3:0] m_code   [NVS];
  bit       m_end;
  int       cyc;

  prc_vs_status_monitor #(
    .NUM_VS(NVS), .TIMEOUT_W(TW), .TIMEOUT_CYCLES(TC)
  ) dut (
    .icap_clk(clk),
    .icap_resetn(rstn),
    .vs_axis_status_tdata(tdata),
    .vs_axis_status_tvalid(tvalid),
    .err_clear(clr),
    .loading_any(loading_any),
    .loading_end(loading_end),
    .release_ok(release_ok),
    .err_sticky(err_sticky),
    .err_code(err_code),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NVS; i++) begin
      m_load[i] = 0; m_err[i] = 0; m_start[i] = 0;
      m_sticky[i] = 0; m_tmo[i] = 0; m_code[i] = 4'd0;
    end
    m_end = 0;
    cyc   = 0;
  endtask

  task automatic model_step();
    logic [2:0] s;
    logic [3:0] e;
    bit         ebeat;
    m_end = 0;
    cyc++;
    for (int i = 0; i < NVS; i++) begin
      s     = tdata[32*i +: 3];
      e     = tdata[32*i+3 +: 4];
      ebeat = tvalid[i] && (e != 4'd0);
      if (clr) begin m_sticky[i] = 0; m_tmo[i] = 0; m_code[i] = 4'd0; end
      if (ebeat) begin
        if (!m_sticky[i]) m_code[i] = e;
        m_sticky[i] = 1;
      end
      if (m_err[i]) begin
        if (clr && !ebeat) m_err[i] = 0;
      end else if (m_load[i]) begin
        if (ebeat) begin
          m_load[i] = 0; m_err[i] = 1;
        end else if (tvalid[i] && s != 3'b100) begin
          m_load[i] = 0; m_end = 1;
        end else if (cyc - m_start[i] == int'(TC)) begin
          m_load[i] = 0; m_err[i] = 1; m_tmo[i] = 1;
        end
      end else begin
        if (ebeat) m_err[i] = 1;
        else if (tvalid[i] && s == 3'b100) begin m_load[i] = 1; m_start[i] = cyc; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NVS-1:0]   e_st, e_to;
    logic [4*NVS-1:0] e_cd;
    bit any_load, any_busy;
    any_load = 0; any_busy = 0;
    for (int i = 0; i < NVS; i++) begin
      e_st[i] = m_sticky[i];
      e_to[i] = m_tmo[i];
      e_cd[4*i +: 4] = m_code[i];
      any_load |= m_load[i];
      any_busy |= m_load[i] | m_err[i] | m_sticky[i] | m_tmo[i];
    end
    chk({tag, ".loading_any"}, 32'(loading_any), 32'(any_load));
    chk({tag, ".loading_end"}, 32'(loading_end), 32'(m_end));
    chk({tag, ".release_ok"},  32'(release_ok),  32'(!any_busy));
    chk({tag, ".err_sticky"},  32'(err_sticky),  32'(e_st));
    chk({tag, ".err_code"},    32'(err_code),    32'(e_cd));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(e_to));
  endtask

  // One clock: model advances on the edge, outputs are compared 1ns later, inputs return idle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
    tvalid = '0;
    clr    = 1'b0;
  endtask

  task automatic drive(input int v, input logic [2:0] s, input logic [3:0] e);
    logic [31:0] w;
    w = $urandom();
    w[6:0] = {e, s};
    tdata[32*v +: 32] = w;
    tvalid[v] = 1'b1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; tdata = '0; tvalid = '0; clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.release_ok", 32'(release_ok), 32'd1);
    rstn = 1'b1;

    // Clean load on VS0, exit beat five cycles after entry.
    drive(0, 3'b100, 4'd0); tick();
    chk("t1.loading_any", 32'(loading_any), 32'd1);
    repeat (4) tick();
    drive(0, 3'b000, 4'd0); tick();
    chk("t1.end_pulse", 32'(loading_end), 32'd1);
    chk("t1.release", 32'(release_ok), 32'd1);
    tick();
    chk("t1.end_single", 32'(loading_end), 32'd0);

    // Error during VS1 load, later error keeps first code, then clear.
    drive(1, 3'b100, 4'd0); tick();
    tdata[63:32] = 32'h0000_0024; tvalid[1] = 1'b1; tick();
    chk("t2.sticky", 32'(err_sticky), 32'b10);
    chk("t2.code", 32'(err_code[7:4]), 32'd4);
    chk("t2.release", 32'(release_ok), 32'd0);
    drive(1, 3'b000, 4'd2); tick();
    chk("t2.code_held", 32'(err_code[7:4]), 32'd4);
    clr = 1'b1; tick();
    chk("t2.cleared", 32'({err_sticky, err_code, timeout_err}), 32'd0);
    chk("t2.release_back", 32'(release_ok), 32'd1);

    // Timeout exactly TC cycles after entry.
    drive(0, 3'b100, 4'd0); tick();
    repeat (TC - 1) tick();
    chk("t3.no_tmo_yet", 32'(timeout_err[0]), 32'd0);
    tick();
    chk("t3.tmo", 32'(timeout_err[0]), 32'd1);
    chk("t3.no_end", 32'(loading_end), 32'd0);
    repeat (3) tick();
    chk("t3.held", 32'(release_ok), 32'd0);
    clr = 1'b1; tick();
    chk("t3.cleared", 32'(release_ok), 32'd1);

    // Simultaneous exits give one pulse; adjacent exits give two.
    drive(0, 3'b100, 4'd0); drive(1, 3'b100, 4'd0); tick(); tick();
    drive(0, 3'b001, 4'd0); drive(1, 3'b000, 4'd0); tick();
    chk("t4.joint_end", 32'(loading_end), 32'd1);
    tick();
    chk("t4.joint_single", 32'(loading_end), 32'd0);
    drive(0, 3'b100, 4'd0); drive(1, 3'b100, 4'd0); tick();
    drive(0, 3'b000, 4'd0); tick();
    chk("t4.adj_first", 32'(loading_end), 32'd1);
    drive(1, 3'b000, 4'd0); tick();
    chk("t4.adj_second", 32'(loading_end), 32'd1);
    tick();
    chk("t4.adj_done", 32'(loading_end), 32'd0);

    // Clear collides with an error beat: the error wins.
    drive(0, 3'b000, 4'd1); clr = 1'b1; tick();
    chk("t5.sticky", 32'(err_sticky[0]), 32'd1);
    chk("t5.code", 32'(err_code[3:0]), 32'd1);
    chk("t5.release", 32'(release_ok), 32'd0);
    drive(0, 3'b000, 4'd3); tick();
    drive(0, 3'b000, 4'd6); clr = 1'b1; tick();
    chk("t5.code_after_clear", 32'(err_code[3:0]), 32'd6);
    clr = 1'b1; tick();

    // Reset during a VS1 load, then a fresh load restarts the count.
    drive(1, 3'b100, 4'd0); tick();
    repeat (7) tick();
    async_reset();
    chk("t6.any", 32'(loading_any), 32'd0);
    chk("t6.release", 32'(release_ok), 32'd1);
    drive(1, 3'b100, 4'd0); tick();
    chk("t6.no_end", 32'(loading_end), 32'd0);
    repeat (TC - 1) tick();
    chk("t6.no_tmo_yet", 32'(timeout_err[1]), 32'd0);
    tick();
    chk("t6.tmo", 32'(timeout_err[1]), 32'd1);
    clr = 1'b1; tick();

    // Random status traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int v = 0; v < NVS; v++) begin
        if ($urandom_range(0, 5) == 0) begin
          logic [2:0] s;
          logic [3:0] e;
          case ($urandom_range(0, 2))
            0:       s = 3'b100;
            1:       s = 3'b000;
            default: s = 3'($urandom());
          endcase
          e = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : 4'd0;
          drive(v, s, e);
        end
      end
      clr = ($urandom_range(0, 24) == 0);
      tick();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
